mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory between the CPU instruction-fetch port and the load/store data port.
- Replaces ad-hoc address muxing with a sequenced req/ack protocol, so fetch and data accesses never collide.
- Sits between the CPU core and the memory block, and owns the memory address, write-data and write-enable lines.
- Arbitration is round-robin, so neither requester starves.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MEM_LAT, 1, memory read latency in clk cycles; legal range 1..15.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  instruction fetch request; level, held until if_ack.
- if_addr  in  AW  fetch address; stable while if_req=1.
- if_rdata  out  DW  fetched word; valid when if_ack=1 and held afterwards.
- if_ack  out  1  one-cycle completion pulse.
- d_req  in  1  data request; level, held until d_ack.
- d_we  in  1  1=store, 0=load; stable while d_req=1.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_rdata  out  DW  load data; valid when d_ack=1 and held afterwards.
- d_ack  out  1  one-cycle completion pulse.
- mem_addr  out  AW  address to memory.
- mem_wdata  out  DW  write data to memory.
- mem_we  out  1  memory write strobe.
- mem_rdata  in  DW  memory read data; valid MEM_LAT cycles after the address is presented.
- busy  out  1  1 when the FSM is not in IDLE.
- owner  out  1  port of the current or last grant: 0=IF, 1=D.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - if_ack, d_ack, mem_we and busy are 0.
  - mem_addr, mem_wdata, if_rdata and d_rdata are 0.
  - owner=0.
  - last_gnt=IF, so D wins the first conflict.
  - Latency counter is 0.
- Reset asserted mid-transaction aborts it: no ack is issued, and a store that has not yet seen mem_we is never written.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - Requests are sampled each cycle.
  - Only one req high: grant that port.
  - Both high: grant the port that is not last_gnt.
  - On grant, register address, we and wdata from the granted port, and set owner and last_gnt.
  - Next state is ACCESS, counter=0.
  - With no request, stay in IDLE.
- ACCESS:
  - Lasts exactly MEM_LAT cycles.
  - mem_addr and mem_wdata are driven from the registered values.
  - mem_we=1 only in the first ACCESS cycle, and only for a D store; IF is never a write.
  - Counter increments each cycle; on the last cycle, mem_rdata is captured into if_rdata or d_rdata of the owner (loads and fetches only).
  - Next state is RESP.
- RESP:
  - The owner's ack=1 for exactly one cycle; the other ack stays 0.
  - Next state is IDLE.
  - Requests are not sampled in RESP.
- Requester rule: drop req on the clock edge that samples ack=1. A req still high in the following IDLE cycle counts as a new request.
- Timing: req first high in IDLE cycle t gives ack in cycle t+MEM_LAT+1. Back-to-back throughput is one transaction per MEM_LAT+2 cycles.
- Store: d_rdata is unchanged, and d_ack follows the same timing as a load.
- mem_addr and mem_wdata hold their last values outside ACCESS. mem_we is 0 outside the first ACCESS cycle.
- if_rdata and d_rdata change only on their own captures.
- Changing a request's inputs while it is pending is a protocol violation. The captured values are used, so the change has no effect on the transaction in flight.
- busy=1 in ACCESS and RESP.
- Width rules: addresses and data pass through unmodified, with no alignment or extension.

Test Plan:
- Single fetch, MEM_LAT=1: if_req=1 with if_addr=0x10 in IDLE cycle 0 -> mem_addr=0x10 in cycle 1; mem_rdata=0xDEADBEEF captured; if_ack=1 and if_rdata=0xDEADBEEF in cycle 2; busy=1 in cycles 1-2.
- Store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0x1234 -> mem_we=1 for one cycle with mem_addr=0x40 and mem_wdata=0x1234; d_ack follows one cycle later; d_rdata stays 0.
- Conflict after reset: if_req and d_req high in the same IDLE cycle -> D granted first (owner=1); then IF completes; each ack comes one transaction apart, 3 cycles with MEM_LAT=1.
- Round-robin fairness: both req held continuously and re-asserted after each ack for 6 transactions -> grants alternate D, IF, D, IF, D, IF.
- MEM_LAT=3 load: mem_rdata valid 3 cycles after the address -> d_ack 4 cycles after the request; mem_we is never asserted.
- Mid-transaction reset: rst=0 during ACCESS of a fetch -> all outputs go to reset values immediately; no if_ack is issued; after release, a new fetch completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the instruction-fetch
// port (IF) and the load/store data port (D) using a req/ack handshake.
//
// Each transaction is sequenced as IDLE -> ACCESS (MEM_LAT cycles) -> RESP -> IDLE.
// When both ports request in the same cycle, round-robin arbitration grants the
// port that did not win last time.
//
// Ports:
//   clk_i, rst_ni             clock; asynchronous active-low reset
//   if_req_i, if_addr_i       fetch request (level) and fetch address
//   if_rdata_o, if_ack_o      fetched word (held) and one-cycle completion pulse
//   d_req_i, d_we_i           data request (level); 1 = store, 0 = load
//   d_addr_i, d_wdata_i       data address and store data
//   d_rdata_o, d_ack_o        load data (held) and one-cycle completion pulse
//   mem_addr_o, mem_wdata_o   memory address and write data (held outside ACCESS)
//   mem_we_o                  write strobe, first ACCESS cycle of a store only
//   mem_rdata_i               read data, valid MEM_LAT cycles after the address
//   busy_o                    high in ACCESS and RESP
//   owner_o                   port of the current or last grant (0 = IF, 1 = D)
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1   // legal range 1..15
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_ack_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic [DW-1:0] d_rdata_o,
  output logic          d_ack_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_we_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o,
  output logic          owner_o
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [3:0] LastCnt = 4'(MEM_LAT - 1);

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic          we_q;        // captured d_we of the granted request
  logic          owner_q;     // doubles as last_gnt: same value, same reset (IF)
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          mem_we_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          if_ack_q;
  logic          d_ack_q;
  logic          busy_q;

  // D wins when it is the only requester, or on a conflict when IF won last time.
  logic gnt_d;
  always_comb begin
    gnt_d = d_req_i & (~if_req_i | ~owner_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      owner_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // Pulses default low; set only where they belong.
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      mem_we_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (if_req_i || d_req_i) begin
            state_q    <= StAccess;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            owner_q    <= gnt_d;
            we_q       <= gnt_d & d_we_i;
            mem_we_q   <= gnt_d & d_we_i;
            mem_addr_q <= gnt_d ? d_addr_i : if_addr_i;
            // IF has no write data; leave the bus holding its last value.
            if (gnt_d) begin
              mem_wdata_q <= d_wdata_i;
            end
          end
        end
        StAccess: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LastCnt) begin
            state_q <= StResp;
            if (owner_q) begin
              d_ack_q <= 1'b1;
              if (!we_q) begin
                d_rdata_q <= mem_rdata_i;
              end
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= mem_rdata_i;
            end
          end
        end
        StResp: begin
          // Requests are deliberately not sampled here; the requester drops req
          // on this edge, so a req seen in the next IDLE is a new request.
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign if_rdata_o  = if_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_ack_o     = d_ack_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_we_o    = mem_we_q;
  assign busy_o      = busy_q;
  assign owner_o     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: sequencer pushes expected acks (data and
// cycle) per port, a negedge monitor pops and compares whenever an ack appears.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // DUT with MEM_LAT=1
  logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          if_ack, d_ack, mem_we, busy, owner;

  // DUT with MEM_LAT=3 (data port exercised only)
  logic          d_req3 = 1'b0;
  logic [AW-1:0] d_addr3 = '0;
  logic [DW-1:0] if_rdata3, d_rdata3, mem_wdata3, mem_rdata3;
  logic [AW-1:0] mem_addr3;
  logic          if_ack3, d_ack3, mem_we3, busy3, owner3;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_rdata_o(d_rdata), .d_ack_o(d_ack),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we),
    .mem_rdata_i(mem_rdata), .busy_o(busy), .owner_o(owner)
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(1'b0), .if_addr_i('0), .if_rdata_o(if_rdata3), .if_ack_o(if_ack3),
    .d_req_i(d_req3), .d_we_i(1'b0), .d_addr_i(d_addr3), .d_wdata_i('0),
    .d_rdata_o(d_rdata3), .d_ack_o(d_ack3),
    .mem_addr_o(mem_addr3), .mem_wdata_o(mem_wdata3), .mem_we_o(mem_we3),
    .mem_rdata_i(mem_rdata3), .busy_o(busy3), .owner_o(owner3)
  );

  // Memory model: fixed pattern C0DE00xx, 0x10 holds DEADBEEF, plus one stored word.
  logic          st_valid = 1'b0;
  logic [7:0]    st_addr = '0;
  logic [DW-1:0] st_data = '0;
  always @(posedge clk) begin
    if (mem_we) begin
      st_valid <= 1'b1;
      st_addr  <= mem_addr[7:0];
      st_data  <= mem_wdata;
    end
  end

  always_comb begin
    if (st_valid && mem_addr[7:0] == st_addr) mem_rdata = st_data;
    else if (mem_addr[7:0] == 8'h10)          mem_rdata = 32'hDEADBEEF;
    else                                      mem_rdata = 32'hC0DE0000 | {24'h0, mem_addr[7:0]};
  end

  // Three-cycle memory: read data appears two registers after the address.
  logic [DW-1:0] p0, p1 = '0, p2 = '0;
  always_comb p0 = 32'hC0DE0000 | {24'h0, mem_addr3[7:0]};
  always @(posedge clk) begin
    p1 <= p0;
    p2 <= p1;
  end
  assign mem_rdata3 = p2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard
  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t if_q[$];
  exp_t d_q[$];
  exp_t d3_q[$];
  exp_t me;
  logic we3_seen = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (if_ack && d_ack) check("both acks high", 1, 0);
      if (if_ack) begin
        if (if_q.size() == 0) check("if_ack unexpected", 1, 0);
        else begin
          me = if_q.pop_front();
          check("if_ack cycle", 64'(cyc), 64'(me.cyc));
          check("if_rdata", 64'(if_rdata), 64'(me.data));
          check("owner at if_ack", 64'(owner), 0);
        end
      end
      if (d_ack) begin
        if (d_q.size() == 0) check("d_ack unexpected", 1, 0);
        else begin
          me = d_q.pop_front();
          check("d_ack cycle", 64'(cyc), 64'(me.cyc));
          check("d_rdata", 64'(d_rdata), 64'(me.data));
          check("owner at d_ack", 64'(owner), 1);
        end
      end
      if (d_ack3) begin
        if (d3_q.size() == 0) check("d_ack3 unexpected", 1, 0);
        else begin
          me = d3_q.pop_front();
          check("d_ack3 cycle", 64'(cyc), 64'(me.cyc));
          check("d_rdata3", 64'(d_rdata3), 64'(me.data));
        end
      end
      if (if_ack3) check("if_ack3 unexpected", 1, 0);
      if (mem_we3) we3_seen = 1'b1;
    end
  end

  // Drivers: hold req until ack is seen, then drop it on the following edge.
  task automatic drive_if(input logic [AW-1:0] a);
    bit seen = 0;
    if_req = 1'b1;
    if_addr = a;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (if_ack) seen = 1;
    end
    check("if_ack timeout", 64'(seen), 1);
    @(posedge clk);
    #1 if_req = 1'b0;
  endtask

  task automatic drive_d(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    bit seen = 0;
    d_req = 1'b1;
    d_we = we;
    d_addr = a;
    d_wdata = wd;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (d_ack) seen = 1;
    end
    check("d_ack timeout", 64'(seen), 1);
    @(posedge clk);
    #1 d_req = 1'b0;
  endtask

  task automatic drive_d3(input logic [AW-1:0] a);
    bit seen = 0;
    d_req3 = 1'b1;
    d_addr3 = a;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (d_ack3) seen = 1;
    end
    check("d_ack3 timeout", 64'(seen), 1);
    @(posedge clk);
    #1 d_req3 = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"}, 64'(busy), 0);
    check({tag, " owner"}, 64'(owner), 0);
    check({tag, " if_ack"}, 64'(if_ack), 0);
    check({tag, " d_ack"}, 64'(d_ack), 0);
    check({tag, " mem_we"}, 64'(mem_we), 0);
    check({tag, " mem_addr"}, 64'(mem_addr), 0);
    check({tag, " mem_wdata"}, 64'(mem_wdata), 0);
    check({tag, " if_rdata"}, 64'(if_rdata), 0);
    check({tag, " d_rdata"}, 64'(d_rdata), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int t;

  initial begin
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    #4 rst_n = 1'b1;

    // Conflict right after reset: D first, IF one transaction (3 cycles) later.
    @(posedge clk); #1 t = cyc;
    d_q.push_back('{data: 32'hC0DE0030, cyc: t + 2});
    if_q.push_back('{data: 32'hC0DE0020, cyc: t + 5});
    fork
      drive_d(1'b0, 32'h30, '0);
      drive_if(32'h20);
      begin
        @(posedge clk); #1 check("conflict owner", 64'(owner), 1);
      end
    join

    // Both requests held continuously for 6 transactions: D, IF, D, IF, D, IF.
    @(posedge clk); #1 t = cyc;
    for (int i = 0; i < 3; i++) begin
      d_q.push_back('{data: 32'hC0DE0060, cyc: t + 2 + 6 * i});
      if_q.push_back('{data: 32'hC0DE0050, cyc: t + 5 + 6 * i});
    end
    fork
      begin
        for (int i = 0; i < 3; i++) drive_d(1'b0, 32'h60, '0);
      end
      begin
        for (int i = 0; i < 3; i++) drive_if(32'h50);
      end
    join

    // Single fetch from 0x10.
    @(posedge clk); #1 t = cyc;
    if_q.push_back('{data: 32'hDEADBEEF, cyc: t + 2});
    fork
      drive_if(32'h10);
      begin
        @(posedge clk);
        #1 check("fetch mem_addr", 64'(mem_addr), 64'h10);
        check("fetch busy access", 64'(busy), 1);
        check("fetch mem_we", 64'(mem_we), 0);
        @(posedge clk);
        #1 check("fetch busy resp", 64'(busy), 1);
      end
    join
    check("idle busy", 64'(busy), 0);

    // Store: one-cycle mem_we, d_rdata keeps the previous load value.
    @(posedge clk); #1 t = cyc;
    d_q.push_back('{data: 32'hC0DE0060, cyc: t + 2});
    fork
      drive_d(1'b1, 32'h40, 32'h1234);
      begin
        @(posedge clk);
        #1 check("store mem_we", 64'(mem_we), 1);
        check("store mem_addr", 64'(mem_addr), 64'h40);
        check("store mem_wdata", 64'(mem_wdata), 64'h1234);
        @(posedge clk);
        #1 check("store mem_we resp", 64'(mem_we), 0);
      end
    join

    // Load back the stored word.
    @(posedge clk); #1 t = cyc;
    d_q.push_back('{data: 32'h00001234, cyc: t + 2});
    drive_d(1'b0, 32'h40, '0);

    // MEM_LAT=3 load: ack 4 cycles after the request, no write strobe.
    @(posedge clk); #1 t = cyc;
    d3_q.push_back('{data: 32'hC0DE0024, cyc: t + 4});
    fork
      drive_d3(32'h24);
      begin
        @(posedge clk);
        #1 check("lat3 mem_addr", 64'(mem_addr3), 64'h24);
        check("lat3 busy", 64'(busy3), 1);
      end
    join
    check("lat3 mem_we never", 64'(we3_seen), 0);

    // Reset during the ACCESS of a fetch: no ack, everything back to reset values.
    @(posedge clk); #1;
    if_req = 1'b1;
    if_addr = 32'h70;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    if_req = 1'b0;
    repeat (2) @(posedge clk);
    #5 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("post-reset busy", 64'(busy), 0);

    // Fresh fetch after release completes normally.
    t = cyc;
    if_q.push_back('{data: 32'hDEADBEEF, cyc: t + 2});
    drive_if(32'h10);

    repeat (3) @(posedge clk);
    #1 check("if queue drained", 64'(if_q.size()), 0);
    check("d queue drained", 64'(d_q.size()), 0);
    check("d3 queue drained", 64'(d3_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
